// File: rtl/prim_fifo_pkg.sv
// Shared types and helpers for the watermark sync FIFO: width derivation,
// wrap-aware pointer comparisons and the error-cause encoding.
package prim_fifo_pkg;

  // Widest pointer value the helpers handle (depths up to 2**16 entries).
  localparam int PtrMaxW = 16;

  typedef logic [PtrMaxW:0] pdepth_t;

  // Pointer view: value (zero-extended to PtrMaxW) plus the wrap bit.
  typedef struct packed {
    logic                wrap;
    logic [PtrMaxW-1:0]  value;
  } ptr_t;

  typedef enum logic [1:0] {
    FifoErrNone    = 2'd0,
    FifoErrPtr     = 2'd1,
    FifoErrDropSat = 2'd2
  } fifo_err_e;

  // Bits needed to encode 0..value-1 (at least one bit).
  function automatic int vbits(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int depth_w(int depth);
    return vbits(depth + 1);
  endfunction

  function automatic int ptrv_w(int depth);
    return vbits(depth);
  endfunction

  function automatic logic ptr_empty(ptr_t w, ptr_t r);
    return w == r;
  endfunction

  function automatic logic ptr_full(ptr_t w, ptr_t r);
    return (w.value == r.value) && (w.wrap != r.wrap);
  endfunction

  // Occupancy from two wrap-aware pointers over a ring of 'depth' entries.
  function automatic pdepth_t ptr_depth(ptr_t w, ptr_t r, int depth);
    pdepth_t d_full;
    pdepth_t w_ext;
    pdepth_t r_ext;
    d_full = pdepth_t'(depth);
    w_ext  = {1'b0, w.value};
    r_ext  = {1'b0, r.value};
    if (ptr_full(w, r)) begin
      return d_full;
    end else if (w.wrap == r.wrap) begin
      return w_ext - r_ext;
    end else begin
      return d_full - r_ext + w_ext;
    end
  endfunction

endpackage

// File: rtl/prim_fifo_sync_wm_ptr.sv
// One wrap-aware FIFO pointer: counts 0..Depth-1 and toggles the wrap bit
// each time it rolls over, so full and empty can be told apart.
module prim_fifo_sync_wm_ptr
  import prim_fifo_pkg::*;
#(
  parameter int Depth = 8,
  localparam int PtrVW = ptrv_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             incr_i,
  output logic [PtrVW-1:0] value_o,
  output logic             wrap_o
);

  logic [PtrVW-1:0] value_d, value_q;
  logic             wrap_d, wrap_q;

  // Next pointer: flush wins, otherwise advance with rollover at Depth-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    value_d = value_q;
    wrap_d  = wrap_q;
    if (clr_i) begin
      value_d = '0;
      wrap_d  = 1'b0;
    end else if (incr_i) begin
      if (value_q == PtrVW'(Depth - 1)) begin
        value_d = '0;
        wrap_d  = ~wrap_q;
      end else begin
        value_d = value_q + PtrVW'(1);
      end
    end
  end

  // Pointer state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (!rst_ni) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value_o = value_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Synchronous FIFO with runtime watermarks, optional drop-on-full with a
// saturating drop counter, optional pass-through and sticky error flag.
module prim_fifo_sync_wm
  import prim_fifo_pkg::*;
#(
  parameter int Width             = 16,
  parameter int Depth             = 8,
  parameter bit Pass              = 1'b1,
  parameter bit OutputZeroIfEmpty = 1'b1,
  parameter bit DropOnFull        = 1'b0,
  parameter int CntW              = 8,
  localparam int DepthW           = depth_w(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  input  logic [DepthW-1:0] af_th_i,
  input  logic [DepthW-1:0] ae_th_i,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CntW-1:0]   drop_cnt_o,
  output logic              err_o
);

  localparam int PtrVW = ptrv_w(Depth);

  logic [PtrVW-1:0] wr_value, rd_value;
  logic             wr_wrap, rd_wrap;
  ptr_t             wr_ptr, rd_ptr;
  logic             full, empty, wr_en, rd_en, drop;
  logic [DepthW-1:0] depth;
  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  drop_cnt_d, drop_cnt_q;
  logic             err_d, err_q;
  fifo_err_e        err_cause;

  prim_fifo_sync_wm_ptr #(.Depth(Depth)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .incr_i  (wr_en),
    .value_o (wr_value),
    .wrap_o  (wr_wrap)
  );

  prim_fifo_sync_wm_ptr #(.Depth(Depth)) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .incr_i  (rd_en),
    .value_o (rd_value),
    .wrap_o  (rd_wrap)
  );

  assign wr_ptr = '{wrap: wr_wrap, value: PtrMaxW'(wr_value)};
  assign rd_ptr = '{wrap: rd_wrap, value: PtrMaxW'(rd_value)};
  assign full   = ptr_full(wr_ptr, rd_ptr);
  assign empty  = ptr_empty(wr_ptr, rd_ptr);
  assign depth  = DepthW'(ptr_depth(wr_ptr, rd_ptr, Depth));

  // Handshakes are held off while reset is asserted; clr_i does not gate them.
  assign wready_o = rst_ni & (DropOnFull | ~full);
  assign rvalid_o = rst_ni & (~empty | (Pass & wvalid_i));

  // A full FIFO never stores, even in drop mode where wready_o stays high.
  assign wr_en = wvalid_i & wready_o & ~full & ~clr_i;
  assign rd_en = rvalid_o & rready_i & ~clr_i;
  assign drop  = DropOnFull & wvalid_i & full & ~clr_i;

  // Storage array, written on an accepted write.
  always_ff @(posedge clk_i) begin
    // NOTE: the data array has no reset; it is never observed while empty, and resetting it only costs area.
    if (wr_en) begin
      mem_q[wr_value] <= wdata_i;
    end
  end

  // Read data: head entry, pass-through when empty, zeroed when invalid.
  always_comb begin
    rdata_o = mem_q[rd_value];
    if (Pass && empty) begin
      rdata_o = wdata_i;
    end
    if (OutputZeroIfEmpty && !rvalid_o) begin
      rdata_o = '0;
    end
  end

  // Drop counter saturation and sticky error detection.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_cause  = FifoErrNone;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CntW'(1);
    end
    if ((int'(wr_value) >= Depth) || (int'(rd_value) >= Depth) || (int'(depth) > Depth)) begin
      err_cause = FifoErrPtr;
    end else if (DropOnFull && (drop_cnt_d == '1)) begin
      err_cause = FifoErrDropSat;
    end
    err_d = err_q | (err_cause != FifoErrNone);
    if (clr_i) begin
      drop_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  // Drop counter and error flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign full_o         = full;
  assign depth_o        = depth;
  assign almost_full_o  = (depth >= af_th_i);
  assign almost_empty_o = (depth <= ae_th_i);
  assign drop_cnt_o     = DropOnFull ? drop_cnt_q : '0;
  assign err_o          = err_q;

  a_depth_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(depth_o) <= Depth);
  a_rdata_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> !$isunknown(rdata_o));
  a_no_wr_unready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !wready_o |-> !wr_en);

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Bench for prim_fifo_sync_wm: three configurations driven by one shared
// stimulus stream, each compared against a list-based reference model.
module tb_prim_fifo_sync_wm;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n, clr, wvalid, rready;
  logic [15:0] wdata;
  logic [3:0]  af_th, ae_th;

  logic        wready [N];
  logic        rvalid [N];
  logic        full   [N];
  logic        af     [N];
  logic        ae     [N];
  logic        err    [N];
  logic [15:0] rdata  [N];
  logic [3:0]  depth0;
  logic [2:0]  depth1, depth2;
  logic [7:0]  drop0, drop1;
  logic [1:0]  drop2;

  // Model configuration per instance: 0 = Depth 8 pass, 1 = Depth 5, 2 = Depth 4 drop-on-full.
  int md    [N] = '{8, 5, 4};
  bit mpass [N] = '{1'b1, 1'b0, 1'b0};
  bit mdof  [N] = '{1'b0, 1'b0, 1'b1};
  int mdmax [N] = '{255, 255, 3};

  // Model state: ordered list of held entries, drop count, sticky error.
  logic [15:0] mlist [N][8];
  int          mcnt  [N];
  int          mdrop [N];
  bit          merr  [N];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  prim_fifo_sync_wm #(.Width(16), .Depth(8), .Pass(1'b1), .OutputZeroIfEmpty(1'b1),
                      .DropOnFull(1'b0), .CntW(8)) u_d8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready[0]),
    .wdata_i(wdata), .rvalid_o(rvalid[0]), .rready_i(rready), .rdata_o(rdata[0]),
    .af_th_i(af_th), .ae_th_i(ae_th), .full_o(full[0]), .depth_o(depth0),
    .almost_full_o(af[0]), .almost_empty_o(ae[0]), .drop_cnt_o(drop0), .err_o(err[0])
  );

  prim_fifo_sync_wm #(.Width(16), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1),
                      .DropOnFull(1'b0), .CntW(8)) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready[1]),
    .wdata_i(wdata), .rvalid_o(rvalid[1]), .rready_i(rready), .rdata_o(rdata[1]),
    .af_th_i(af_th[2:0]), .ae_th_i(ae_th[2:0]), .full_o(full[1]), .depth_o(depth1),
    .almost_full_o(af[1]), .almost_empty_o(ae[1]), .drop_cnt_o(drop1), .err_o(err[1])
  );

  prim_fifo_sync_wm #(.Width(16), .Depth(4), .Pass(1'b0), .OutputZeroIfEmpty(1'b1),
                      .DropOnFull(1'b1), .CntW(2)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wready[2]),
    .wdata_i(wdata), .rvalid_o(rvalid[2]), .rready_i(rready), .rdata_o(rdata[2]),
    .af_th_i(af_th[2:0]), .ae_th_i(ae_th[2:0]), .full_o(full[2]), .depth_o(depth2),
    .almost_full_o(af[2]), .almost_empty_o(ae[2]), .drop_cnt_o(drop2), .err_o(err[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of every instance, then advance one clock and the model.
  task automatic step();
    bit          e_full [N];
    bit          e_empty[N];
    bit          e_wr   [N];
    bit          e_rv   [N];
    logic [15:0] e_rd;
    int          af_k, ae_k;
    logic [31:0] o_depth, o_drop;
    bit          wf, rf, dr;
    #1;
    for (int k = 0; k < N; k++) begin
      e_full[k]  = (mcnt[k] == md[k]);
      e_empty[k] = (mcnt[k] == 0);
      e_wr[k]    = rst_n && (mdof[k] || !e_full[k]);
      e_rv[k]    = rst_n && (!e_empty[k] || (mpass[k] && wvalid));
      e_rd       = !e_rv[k] ? 16'h0 : (!e_empty[k] ? mlist[k][0] : wdata);
      af_k       = (k == 0) ? int'(af_th) : int'(af_th[2:0]);
      ae_k       = (k == 0) ? int'(ae_th) : int'(ae_th[2:0]);
      case (k)
        0:       begin o_depth = 32'(depth0); o_drop = 32'(drop0); end
        1:       begin o_depth = 32'(depth1); o_drop = 32'(drop1); end
        default: begin o_depth = 32'(depth2); o_drop = 32'(drop2); end
      endcase
      check($sformatf("wready[%0d]", k), 32'(wready[k]), 32'(e_wr[k]));
      check($sformatf("rvalid[%0d]", k), 32'(rvalid[k]), 32'(e_rv[k]));
      check($sformatf("rdata[%0d]", k),  32'(rdata[k]),  32'(e_rd));
      check($sformatf("full[%0d]", k),   32'(full[k]),   32'(e_full[k]));
      check($sformatf("depth[%0d]", k),  o_depth,        32'(mcnt[k]));
      check($sformatf("afull[%0d]", k),  32'(af[k]),     32'(mcnt[k] >= af_k));
      check($sformatf("aempty[%0d]", k), 32'(ae[k]),     32'(mcnt[k] <= ae_k));
      check($sformatf("drop[%0d]", k),   o_drop,         32'(mdrop[k]));
      check($sformatf("err[%0d]", k),    32'(err[k]),    32'(merr[k]));
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (!rst_n || clr) begin
        mcnt[k]  = 0;
        mdrop[k] = 0;
        merr[k]  = 1'b0;
      end else begin
        wf = wvalid && e_wr[k] && !e_full[k];
        rf = e_rv[k] && rready;
        dr = mdof[k] && wvalid && e_full[k];
        if (rf && !e_empty[k]) begin
          for (int i = 0; i < 7; i++) mlist[k][i] = mlist[k][i+1];
          mcnt[k]--;
        end
        if (wf && !(rf && e_empty[k])) begin
          mlist[k][mcnt[k]] = wdata;
          mcnt[k]++;
        end
        if (dr && (mdrop[k] < mdmax[k])) mdrop[k]++;
        if (mdrop[k] == mdmax[k]) merr[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] d);
    wvalid = 1'b1; rready = 1'b0; wdata = d;
    step();
  endtask

  task automatic rd();
    wvalid = 1'b0; rready = 1'b1;
    step();
  endtask

  task automatic flush();
    wvalid = 1'b0; rready = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
    af_th = 4'd6; ae_th = 4'd1;
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0; mdrop[k] = 0; merr[k] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    #1;
    check("reset_depth", 32'(depth0), 32'd0);
    check("reset_rvalid", 32'(rvalid[0]), 32'd0);

    // Fill with 0x11..0x88: Depth 8 fills exactly, Depth 5 refuses, Depth 4 drops.
    for (int i = 1; i <= 8; i++) wr(16'(i * 'h11));
    wvalid = 1'b0;
    #1;
    check("t1_full", 32'(full[0]), 32'd1);
    check("t1_depth", 32'(depth0), 32'd8);
    check("t1_wready", 32'(wready[0]), 32'd0);
    check("t5_drop_sat", 32'(drop2), 32'd3);
    check("t5_err", 32'(err[2]), 32'd1);
    check("t2_depth5", 32'(depth1), 32'd5);
    for (int i = 1; i <= 8; i++) begin
      wvalid = 1'b0; rready = 1'b1;
      #1;
      check($sformatf("t1_rdata%0d", i), 32'(rdata[0]), 32'(i * 'h11));
      step();
    end
    check("t1_empty_depth", 32'(depth0), 32'd0);
    flush();
    #1;
    check("t5_clr_depth", 32'(depth2), 32'd0);
    check("t5_clr_drop", 32'(drop2), 32'd0);
    check("t5_clr_err", 32'(err[2]), 32'd0);

    // Interleaved traffic wrapping the non-power-of-two pointers.
    for (int i = 0; i < 3; i++) wr(16'($urandom));
    for (int i = 0; i < 13; i++) begin
      wvalid = 1'b1; rready = 1'b1; wdata = 16'($urandom);
      step();
    end
    for (int i = 0; i < 8; i++) rd();
    check("t2_err", 32'(err[1]), 32'd0);

    // Pass-through on an empty FIFO.
    wvalid = 1'b1; rready = 1'b1; wdata = 16'hABCD;
    #1;
    check("t3_pass_rdata", 32'(rdata[0]), 32'hABCD);
    check("t3_pass_rvalid", 32'(rvalid[0]), 32'd1);
    step();
    check("t3_pass_depth", 32'(depth0), 32'd0);
    flush();

    // Watermarks: af_th=6, ae_th=1.
    af_th = 4'd6; ae_th = 4'd1;
    for (int i = 1; i <= 6; i++) begin
      wr(16'(16'h0100 + i));
      if (i == 5) check("t4_af_at5", 32'(af[0]), 32'd0);
      if (i == 6) check("t4_af_at6", 32'(af[0]), 32'd1);
    end
    for (int i = 1; i <= 5; i++) begin
      rd();
      if (i == 4) check("t4_ae_at2", 32'(ae[0]), 32'd0);
      if (i == 5) check("t4_ae_at1", 32'(ae[0]), 32'd1);
    end
    flush();

    // Reset pulse in the middle of operation.
    for (int i = 0; i < 3; i++) wr(16'($urandom));
    check("t6_depth3", 32'(depth0), 32'd3);
    rst_n = 1'b0; wvalid = 1'b0; rready = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("t6_depth_after", 32'(depth0), 32'd0);
    check("t6_rvalid_after", 32'(rvalid[0]), 32'd0);
    step();

    // Random traffic with occasional flushes, resets and threshold changes.
    for (int c = 0; c < 600; c++) begin
      if ((c % 50) == 0) begin
        af_th = 4'($urandom_range(0, 15));
        ae_th = 4'($urandom_range(0, 15));
      end
      v      = 16'($urandom);
      wdata  = v;
      wvalid = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rready = ($urandom_range(0, 1) == 1);
      clr    = ($urandom_range(0, 59) == 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1'b1; clr = 1'b0; wvalid = 1'b0; rready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
